systolic_scheduler: RTL

Sequencing controller for an N×N output-stationary systolic multiplier built from 8-bit-operand / 16-bit-accumulator PEs. Accepts a pair of N×N 8-bit matrices over a valid/ready handshake and clears the array. Drives skewed operands into the array's west (row) and north (column) edges for the required number of cycles. Then captures the array's accumulator outputs and returns the N×N 16-bit result over a second valid/ready handshake.

---
 rtl/systolic_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/systolic_scheduler.sv
// ---------------------------------------------------------------------------
// systolic_scheduler
//
// Sequencing controller for an N x N output-stationary systolic multiplier
// whose PEs take 8-bit operands and keep 16-bit accumulators.
//
// A job goes through these states:
//   IDLE -> CLEAR -> FEED (3N-2 cycles) -> DRAIN -> DONE -> IDLE
//
// - IDLE:  a job (A and B) is accepted over a valid/ready handshake.
// - CLEAR: the array is cleared.
// - FEED:  skewed operands are driven onto the west and north edges.
// - DRAIN: the accumulator plane is captured.
// - DONE:  the result is held until the consumer takes it.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_arst       synchronous active-high reset
//   i_valid      job request (A/B buses valid)
//   o_ready      high only in IDLE
//   i_a_flat     matrix A, A[i][k] at [(i*N+k)*8 +: 8]
//   i_b_flat     matrix B, B[k][j] at [(k*N+j)*8 +: 8]
//   o_array_clr  clears PE accumulators and operand registers (CLEAR state)
//   o_row_a      west-edge operand for row i at [i*8 +: 8] (registered)
//   o_col_b      north-edge operand for column j at [j*8 +: 8] (registered)
//   i_c_flat     array accumulators, C[i][j] at [(i*N+j)*16 +: 16]
//   o_valid      result available (DONE state)
//   i_ready      consumer accepts result on o_valid && i_ready
//   o_result     captured C, same packing as i_c_flat
//   o_busy       high in every state except IDLE
// ---------------------------------------------------------------------------
module systolic_scheduler #(
  parameter int N = 4
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [N*N*8-1:0]      i_a_flat,
  input  logic [N*N*8-1:0]      i_b_flat,
  output logic                  o_array_clr,
  output logic [N*8-1:0]        o_row_a,
  output logic [N*8-1:0]        o_col_b,
  input  logic [N*N*16-1:0]     i_c_flat,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [N*N*16-1:0]     o_result,
  output logic                  o_busy
);

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int MAT_W  = N * N * DATA_W;
  localparam int EDGE_W = N * DATA_W;
  localparam int RES_W  = N * N * ACC_W;

  // The feed index runs from 0 to 3N-3.
  // 3N-2 distinct values need $clog2(3N-2) bits.
  localparam int T_LAST = 3 * N - 3;
  localparam int T_W    = $clog2(3 * N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [MAT_W-1:0]    a_q, a_d;
  logic [MAT_W-1:0]    b_q, b_d;
  logic [EDGE_W-1:0]   row_q, row_d;
  logic [EDGE_W-1:0]   col_q, col_d;
  logic [RES_W-1:0]    result_q, result_d;

  // West edge for feed index t.
  // Row i is delayed by i cycles, so it carries A[i][t-i] while that
  // column index is in range. Otherwise the row is zero.
  function automatic logic [EDGE_W-1:0] west_edge(input logic [MAT_W-1:0] a,
                                                  input int t);
    logic [EDGE_W-1:0] e;
    int k;
    e = '0;
    for (int i = 0; i < N; i++) begin
      k = t - i;
      if (k >= 0 && k < N) begin
        e[i*DATA_W +: DATA_W] = a[(i*N+k)*DATA_W +: DATA_W];
      end
    end
    return e;
  endfunction

  // North edge for feed index t.
  // Column j is delayed by j cycles, so it carries B[t-j][j] while that
  // row index is in range. Otherwise the column is zero.
  function automatic logic [EDGE_W-1:0] north_edge(input logic [MAT_W-1:0] b,
                                                   input int t);
    logic [EDGE_W-1:0] e;
    int k;
    e = '0;
    for (int j = 0; j < N; j++) begin
      k = t - j;
      if (k >= 0 && k < N) begin
        e[j*DATA_W +: DATA_W] = b[(k*N+j)*DATA_W +: DATA_W];
      end
    end
    return e;
  endfunction

  // Next-state logic.
  // The edge registers are loaded one cycle ahead: the values for feed
  // index t are computed while entering or advancing FEED. This way they
  // are on the outputs during FEED cycle t. Any cycle that is not heading
  // into a FEED cycle loads zeros.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    row_d    = '0;
    col_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_a_flat;
          b_d     = i_b_flat;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = '0;
        row_d   = west_edge(a_q, 0);
        col_d   = north_edge(b_q, 0);
      end

      S_FEED: begin
        if (t_q == T_W'(T_LAST)) begin
          // The counter holds at its last value; CLEAR re-zeroes it.
          state_d = S_DRAIN;
        end else begin
          t_d   = t_q + T_W'(1);
          row_d = west_edge(a_q, int'(t_d));
          col_d = north_edge(b_q, int'(t_d));
        end
      end

      S_DRAIN: begin
        // The last product entered the array at the end of the final FEED
        // cycle, so the accumulator plane is complete during this cycle.
        result_d = i_c_flat;
        state_d  = S_DONE;
      end

      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  // Reset clears every register, including the operand stores and the
  // result, so an aborted job leaves nothing visible behind.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      a_q      <= a_d;
      b_q      <= b_d;
      row_q    <= row_d;
      col_q    <= col_d;
      result_q <= result_d;
    end
  end

  // Control outputs decoded from the state register.
  assign o_ready     = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_array_clr = (state_q == S_CLEAR);
  assign o_valid     = (state_q == S_DONE);

  assign o_row_a  = row_q;
  assign o_col_b  = col_q;
  assign o_result = result_q;

endmodule
